// File: rtl/quad_encoder_pkg.sv
// Shared types and speed-limit helpers for the quadrature encoder tracker.
package quad_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  function automatic longint speed_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint speed_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/quad_encoder_tracker_if.sv
// Snapshot valid/ready channel from the tracker to the control loop or register bank.
interface quad_encoder_tracker_if #(
  parameter int POS_WIDTH   = 32,
  parameter int SPEED_WIDTH = 16
);
  logic                          snap_valid;
  logic                          snap_ready;
  logic signed [POS_WIDTH-1:0]   snap_position;
  logic signed [SPEED_WIDTH-1:0] snap_speed;
  logic                          snap_sat;
  logic                          snap_overrun;

  modport master (
    output snap_valid, snap_position, snap_speed, snap_sat, snap_overrun,
    input  snap_ready
  );

  modport slave (
    input  snap_valid, snap_position, snap_speed, snap_sat, snap_overrun,
    output snap_ready
  );
endinterface

// File: rtl/quad_encoder_window_timer.sv
// Free-running window counter; win_end flags the last cycle of a measurement window.
module quad_encoder_window_timer #(
  parameter int WINDOW_WIDTH = 24
) (
  input  logic                    clock,
  input  logic                    srst_n,
  input  logic                    clear,
  input  logic [WINDOW_WIDTH-1:0] window,
  output logic                    win_end
);

  logic [WINDOW_WIDTH-1:0] count_q, count_d;

  // A window shorter than the current count lets the counter wrap before matching.
  always_comb begin
    count_d = clear ? '0 : count_q + WINDOW_WIDTH'(1);
  end

  assign win_end = !clear && (count_q == window);

  always_ff @(posedge clock) begin
    if (!srst_n) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/quad_encoder_tracker.sv
// Position/speed tracker publishing one snapshot per window over a valid/ready channel.
// Optional stall detector enabled by defining QUAD_ENCODER_TRACKER_STALL_EN.
module quad_encoder_tracker
  import quad_encoder_pkg::*;
#(
  parameter int POS_WIDTH    = 32,
  parameter int SPEED_WIDTH  = 16,
  parameter int WINDOW_WIDTH = 24
`ifdef QUAD_ENCODER_TRACKER_STALL_EN
  , parameter int STALL_WINDOWS = 8
`endif
) (
  input  logic                        clock,
  input  logic                        srst_n,
  input  logic                        enable,
  input  logic [WINDOW_WIDTH-1:0]     window,
  input  logic                        load,
  input  logic signed [POS_WIDTH-1:0] load_value,
  input  logic                        direction,
  input  logic                        pulse,
  quad_encoder_tracker_if.master      snap,
  output logic                        stall
);

  localparam logic signed [SPEED_WIDTH-1:0] SPEED_MAX = SPEED_WIDTH'(speed_max(SPEED_WIDTH));
  localparam logic signed [SPEED_WIDTH-1:0] SPEED_MIN = SPEED_WIDTH'(speed_min(SPEED_WIDTH));

  // Returns {clamped, next} for a single +1/-1 step of the speed accumulator.
  function automatic logic [SPEED_WIDTH:0] sat_step(input logic signed [SPEED_WIDTH-1:0] acc,
                                                    input logic down);
    if (!down && acc == SPEED_MAX) return {1'b1, SPEED_MAX};
    if (down && acc == SPEED_MIN)  return {1'b1, SPEED_MIN};
    return {1'b0, down ? acc - SPEED_WIDTH'(1) : acc + SPEED_WIDTH'(1)};
  endfunction

  state_e                        state_q, state_d;
  logic                          win_end;
  logic                          capture, acc_clear, timer_clear;
  logic signed [POS_WIDTH-1:0]   pos_q, pos_d;
  logic signed [SPEED_WIDTH-1:0] acc_q, acc_d;
  logic                          acc_sat_q, acc_sat_d;
  logic [SPEED_WIDTH:0]          stepped;
  logic                          snap_valid_q, snap_valid_d;
  logic signed [POS_WIDTH-1:0]   snap_pos_q, snap_pos_d;
  logic signed [SPEED_WIDTH-1:0] snap_speed_q, snap_speed_d;
  logic                          snap_sat_q, snap_sat_d;
  logic                          snap_ovr_q, snap_ovr_d;

  quad_encoder_window_timer #(.WINDOW_WIDTH(WINDOW_WIDTH)) u_timer (
    .clock   (clock),
    .srst_n  (srst_n),
    .clear   (timer_clear),
    .window  (window),
    .win_end (win_end)
  );

  always_ff @(posedge clock) begin
    if (!srst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (enable) state_d = ST_MEASURE;
      ST_MEASURE: begin
        if (!enable)     state_d = ST_IDLE;
        else if (win_end) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: state_d = enable ? ST_MEASURE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    capture     = (state_q == ST_CAPTURE);
    timer_clear = (state_q != ST_MEASURE);
    acc_clear   = (state_q == ST_IDLE) || (state_d == ST_IDLE);
  end

  // Position tracks in every state; load wins over a coincident pulse.
  always_comb begin
    pos_d = pos_q;
    if (load)       pos_d = load_value;
    else if (pulse) pos_d = direction ? pos_q - POS_WIDTH'(1) : pos_q + POS_WIDTH'(1);
  end

  always_comb begin
    acc_d     = acc_q;
    acc_sat_d = acc_sat_q;
    stepped   = sat_step(acc_q, direction);
    if (acc_clear) begin
      acc_d     = '0;
      acc_sat_d = 1'b0;
    end else if (capture) begin
      acc_d     = pulse ? (direction ? '1 : SPEED_WIDTH'(1)) : '0;
      acc_sat_d = 1'b0;
    end else if (pulse) begin
      acc_d     = stepped[SPEED_WIDTH-1:0];
      acc_sat_d = acc_sat_q | stepped[SPEED_WIDTH];
    end
  end

  // A capture on the same edge as a handshake keeps valid high with fresh data.
  always_comb begin
    snap_valid_d = snap_valid_q;
    snap_pos_d   = snap_pos_q;
    snap_speed_d = snap_speed_q;
    snap_sat_d   = snap_sat_q;
    snap_ovr_d   = snap_ovr_q;
    if (capture) begin
      snap_valid_d = 1'b1;
      snap_pos_d   = pos_q;
      snap_speed_d = acc_q;
      snap_sat_d   = acc_sat_q;
      snap_ovr_d   = snap_valid_q && !snap.snap_ready;
    end else if (snap_valid_q && snap.snap_ready) begin
      snap_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!srst_n) begin
      pos_q        <= '0;
      acc_q        <= '0;
      acc_sat_q    <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_pos_q   <= '0;
      snap_speed_q <= '0;
      snap_sat_q   <= 1'b0;
      snap_ovr_q   <= 1'b0;
    end else begin
      pos_q        <= pos_d;
      acc_q        <= acc_d;
      acc_sat_q    <= acc_sat_d;
      snap_valid_q <= snap_valid_d;
      snap_pos_q   <= snap_pos_d;
      snap_speed_q <= snap_speed_d;
      snap_sat_q   <= snap_sat_d;
      snap_ovr_q   <= snap_ovr_d;
    end
  end

  assign snap.snap_valid    = snap_valid_q;
  assign snap.snap_position = snap_pos_q;
  assign snap.snap_speed    = snap_speed_q;
  assign snap.snap_sat      = snap_sat_q;
  assign snap.snap_overrun  = snap_ovr_q;

`ifdef QUAD_ENCODER_TRACKER_STALL_EN
  localparam int SC_W = $clog2(STALL_WINDOWS + 1);

  logic [SC_W-1:0] zcnt_q, zcnt_d;
  logic            stall_q, stall_d;

  // Counts consecutive zero-speed snapshots, saturating at the stall threshold.
  always_comb begin
    zcnt_d = zcnt_q;
    if (!enable)              zcnt_d = '0;
    else if (capture) begin
      if (acc_q != '0)                       zcnt_d = '0;
      else if (zcnt_q != SC_W'(STALL_WINDOWS)) zcnt_d = zcnt_q + SC_W'(1);
    end
    stall_d = (zcnt_d == SC_W'(STALL_WINDOWS));
  end

  always_ff @(posedge clock) begin
    if (!srst_n) begin
      zcnt_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      zcnt_q  <= zcnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall = stall_q;
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_tracker.sv
// Directed bench for quad_encoder_tracker: 16-bit and 4-bit speed instances share stimulus.
module tb_quad_encoder_tracker;

  logic        clock = 1'b0;
  logic        srst_n, enable, load, direction, pulse, rdy;
  logic [23:0] window;
  logic [31:0] load_value;
  logic        stall_b, stall_s;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clock = ~clock;

  quad_encoder_tracker_if #(.POS_WIDTH(32), .SPEED_WIDTH(16)) ifb ();
  quad_encoder_tracker_if #(.POS_WIDTH(32), .SPEED_WIDTH(4))  ifs ();

  assign ifb.snap_ready = rdy;
  assign ifs.snap_ready = rdy;

  quad_encoder_tracker #(
    .POS_WIDTH(32), .SPEED_WIDTH(16), .WINDOW_WIDTH(24)
`ifdef QUAD_ENCODER_TRACKER_STALL_EN
    , .STALL_WINDOWS(2)
`endif
  ) dut_b (
    .clock(clock), .srst_n(srst_n), .enable(enable), .window(window), .load(load),
    .load_value(load_value), .direction(direction), .pulse(pulse), .snap(ifb), .stall(stall_b)
  );

  quad_encoder_tracker #(
    .POS_WIDTH(32), .SPEED_WIDTH(4), .WINDOW_WIDTH(24)
`ifdef QUAD_ENCODER_TRACKER_STALL_EN
    , .STALL_WINDOWS(2)
`endif
  ) dut_s (
    .clock(clock), .srst_n(srst_n), .enable(enable), .window(window), .load(load),
    .load_value(load_value), .direction(direction), .pulse(pulse), .snap(ifs), .stall(stall_s)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_cycles(input int n, input logic [63:0] mask, input logic dir);
    for (int i = 0; i < n; i++) begin
      pulse     = mask[i];
      direction = dir;
      tick();
    end
    pulse = 1'b0;
  endtask

  task automatic do_reset();
    srst_n = 1'b0; enable = 1'b0; load = 1'b0; pulse = 1'b0;
    tick(); tick();
    srst_n = 1'b1;
  endtask

  task automatic test_reset();
    srst_n = 1'b0; enable = 1'b1; pulse = 1'b1; rdy = 1'b1; window = 24'd0;
    tick(); tick();
    n_vec++; if (ifb.snap_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %0b want 0", ifb.snap_valid); end
    n_vec++; if (ifb.snap_position !== 32'sd0) begin n_bad++; $display("FAIL rst_pos got %0h want 0", ifb.snap_position); end
    n_vec++; if (ifb.snap_speed !== 16'sd0) begin n_bad++; $display("FAIL rst_speed got %0h want 0", ifb.snap_speed); end
    n_vec++; if (ifb.snap_sat !== 1'b0) begin n_bad++; $display("FAIL rst_sat got %0b want 0", ifb.snap_sat); end
    n_vec++; if (ifb.snap_overrun !== 1'b0) begin n_bad++; $display("FAIL rst_ovr got %0b want 0", ifb.snap_overrun); end
    n_vec++; if (stall_b !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %0b want 0", stall_b); end
    srst_n = 1'b1; enable = 1'b0; pulse = 1'b0;
    tick();
  endtask

  task automatic test_count_up();
    window = 24'd9; rdy = 1'b1; enable = 1'b1;
    drive_cycles(11, 64'h54, 1'b0);
    n_vec++; if (ifb.snap_valid !== 1'b0) begin n_bad++; $display("FAIL up_early_valid got %0b want 0", ifb.snap_valid); end
    drive_cycles(1, 64'h0, 1'b0);
    n_vec++; if (ifb.snap_valid !== 1'b1) begin n_bad++; $display("FAIL up_valid got %0b want 1", ifb.snap_valid); end
    n_vec++; if (ifb.snap_speed !== 16'sd3) begin n_bad++; $display("FAIL up_speed got %0d want 3", ifb.snap_speed); end
    n_vec++; if (ifb.snap_position !== 32'sd3) begin n_bad++; $display("FAIL up_pos got %0d want 3", ifb.snap_position); end
    n_vec++; if (ifb.snap_sat !== 1'b0) begin n_bad++; $display("FAIL up_sat got %0b want 0", ifb.snap_sat); end
    n_vec++; if (ifb.snap_overrun !== 1'b0) begin n_bad++; $display("FAIL up_ovr got %0b want 0", ifb.snap_overrun); end
    tick();
    n_vec++; if (ifb.snap_valid !== 1'b0) begin n_bad++; $display("FAIL up_accept got %0b want 0", ifb.snap_valid); end
    enable = 1'b0;
    tick(); tick();
  endtask

  task automatic test_count_down();
    do_reset();
    window = 24'd9; rdy = 1'b1; enable = 1'b1;
    drive_cycles(12, 64'h7C, 1'b1);
    n_vec++; if (ifb.snap_valid !== 1'b1) begin n_bad++; $display("FAIL dn_valid got %0b want 1", ifb.snap_valid); end
    n_vec++; if (ifb.snap_speed !== 16'hFFFB) begin n_bad++; $display("FAIL dn_speed got %0h want fffb", ifb.snap_speed); end
    n_vec++; if (ifb.snap_position !== 32'hFFFF_FFFB) begin n_bad++; $display("FAIL dn_pos got %0h want fffffffb", ifb.snap_position); end
    enable = 1'b0;
    tick(); tick();
  endtask

  task automatic test_wrap();
    load = 1'b1; load_value = 32'h7FFF_FFFF;
    tick();
    load = 1'b0; window = 24'd3; enable = 1'b1;
    drive_cycles(6, 64'h2, 1'b0);
    n_vec++; if (ifb.snap_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_valid got %0b want 1", ifb.snap_valid); end
    n_vec++; if (ifb.snap_position !== 32'h8000_0000) begin n_bad++; $display("FAIL wrap_pos got %0h want 80000000", ifb.snap_position); end
    n_vec++; if (ifb.snap_speed !== 16'sd1) begin n_bad++; $display("FAIL wrap_speed got %0d want 1", ifb.snap_speed); end
    enable = 1'b0;
    tick(); tick();
  endtask

  task automatic test_saturation();
    do_reset();
    window = 24'd15; rdy = 1'b1; enable = 1'b1;
    drive_cycles(18, 64'h303FE, 1'b0);
    n_vec++; if (ifb.snap_speed !== 16'sd10) begin n_bad++; $display("FAIL sat_b_speed got %0d want 10", ifb.snap_speed); end
    n_vec++; if (ifb.snap_sat !== 1'b0) begin n_bad++; $display("FAIL sat_b_flag got %0b want 0", ifb.snap_sat); end
    n_vec++; if (ifb.snap_position !== 32'sd10) begin n_bad++; $display("FAIL sat_b_pos got %0d want 10", ifb.snap_position); end
    n_vec++; if (ifs.snap_valid !== 1'b1) begin n_bad++; $display("FAIL sat_s_valid got %0b want 1", ifs.snap_valid); end
    n_vec++; if (ifs.snap_speed !== 4'sd7) begin n_bad++; $display("FAIL sat_s_speed got %0d want 7", ifs.snap_speed); end
    n_vec++; if (ifs.snap_sat !== 1'b1) begin n_bad++; $display("FAIL sat_s_flag got %0b want 1", ifs.snap_sat); end
    drive_cycles(17, 64'h0, 1'b0);
    n_vec++; if (ifb.snap_speed !== 16'sd1) begin n_bad++; $display("FAIL sat2_b_speed got %0d want 1", ifb.snap_speed); end
    n_vec++; if (ifb.snap_position !== 32'sd11) begin n_bad++; $display("FAIL sat2_b_pos got %0d want 11", ifb.snap_position); end
    n_vec++; if (ifs.snap_valid !== 1'b1) begin n_bad++; $display("FAIL sat2_s_valid got %0b want 1", ifs.snap_valid); end
    n_vec++; if (ifs.snap_speed !== 4'sd1) begin n_bad++; $display("FAIL sat2_s_speed got %0d want 1", ifs.snap_speed); end
    n_vec++; if (ifs.snap_sat !== 1'b0) begin n_bad++; $display("FAIL sat2_s_flag got %0b want 0", ifs.snap_sat); end
    n_vec++; if (ifs.snap_overrun !== 1'b0) begin n_bad++; $display("FAIL sat2_s_ovr got %0b want 0", ifs.snap_overrun); end
    enable = 1'b0;
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    window = 24'd3; rdy = 1'b0; enable = 1'b1;
    drive_cycles(6, 64'h2, 1'b0);
    n_vec++; if (ifb.snap_speed !== 16'sd1) begin n_bad++; $display("FAIL ovr1_speed got %0d want 1", ifb.snap_speed); end
    n_vec++; if (ifb.snap_overrun !== 1'b0) begin n_bad++; $display("FAIL ovr1_flag got %0b want 0", ifb.snap_overrun); end
    drive_cycles(5, 64'h3, 1'b0);
    n_vec++; if (ifb.snap_valid !== 1'b1) begin n_bad++; $display("FAIL ovr2_valid got %0b want 1", ifb.snap_valid); end
    n_vec++; if (ifb.snap_speed !== 16'sd2) begin n_bad++; $display("FAIL ovr2_speed got %0d want 2", ifb.snap_speed); end
    n_vec++; if (ifb.snap_position !== 32'sd3) begin n_bad++; $display("FAIL ovr2_pos got %0d want 3", ifb.snap_position); end
    n_vec++; if (ifb.snap_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr2_flag got %0b want 1", ifb.snap_overrun); end
    drive_cycles(4, 64'h7, 1'b0);
    n_vec++; if (ifb.snap_speed !== 16'sd2) begin n_bad++; $display("FAIL ovr_hold_speed got %0d want 2", ifb.snap_speed); end
    rdy = 1'b1;
    tick();
    n_vec++; if (ifb.snap_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid got %0b want 1", ifb.snap_valid); end
    n_vec++; if (ifb.snap_speed !== 16'sd3) begin n_bad++; $display("FAIL b2b_speed got %0d want 3", ifb.snap_speed); end
    n_vec++; if (ifb.snap_overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_ovr got %0b want 0", ifb.snap_overrun); end
    tick();
    n_vec++; if (ifb.snap_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drop got %0b want 0", ifb.snap_valid); end
    enable = 1'b0;
    tick(); tick();
  endtask

  task automatic test_load_and_midreset();
    do_reset();
    window = 24'd3; rdy = 1'b0; enable = 1'b1; load_value = 32'd1000;
    drive_cycles(4, 64'h4, 1'b0);
    load = 1'b1; pulse = 1'b1; direction = 1'b0;
    tick();
    load = 1'b0; pulse = 1'b0;
    tick();
    n_vec++; if (ifb.snap_valid !== 1'b1) begin n_bad++; $display("FAIL ld_valid got %0b want 1", ifb.snap_valid); end
    n_vec++; if (ifb.snap_position !== 32'sd1000) begin n_bad++; $display("FAIL ld_pos got %0d want 1000", ifb.snap_position); end
    n_vec++; if (ifb.snap_speed !== 16'sd2) begin n_bad++; $display("FAIL ld_speed got %0d want 2", ifb.snap_speed); end
    drive_cycles(3, 64'h7, 1'b0);
    srst_n = 1'b0;
    tick();
    n_vec++; if (ifb.snap_valid !== 1'b0) begin n_bad++; $display("FAIL mr_valid got %0b want 0", ifb.snap_valid); end
    n_vec++; if (ifb.snap_position !== 32'sd0) begin n_bad++; $display("FAIL mr_pos got %0d want 0", ifb.snap_position); end
    n_vec++; if (ifb.snap_speed !== 16'sd0) begin n_bad++; $display("FAIL mr_speed got %0d want 0", ifb.snap_speed); end
    n_vec++; if (ifb.snap_sat !== 1'b0 || ifb.snap_overrun !== 1'b0) begin n_bad++; $display("FAIL mr_flags got %0b%0b want 00", ifb.snap_sat, ifb.snap_overrun); end
    srst_n = 1'b1; rdy = 1'b1;
    drive_cycles(5, 64'h0, 1'b0);
    n_vec++; if (ifb.snap_valid !== 1'b0) begin n_bad++; $display("FAIL mr_early got %0b want 0", ifb.snap_valid); end
    tick();
    n_vec++; if (ifb.snap_valid !== 1'b1) begin n_bad++; $display("FAIL mr_fresh_valid got %0b want 1", ifb.snap_valid); end
    n_vec++; if (ifb.snap_speed !== 16'sd0) begin n_bad++; $display("FAIL mr_fresh_speed got %0d want 0", ifb.snap_speed); end
    n_vec++; if (ifb.snap_position !== 32'sd0) begin n_bad++; $display("FAIL mr_fresh_pos got %0d want 0", ifb.snap_position); end
    enable = 1'b0;
    tick(); tick();
  endtask

`ifdef QUAD_ENCODER_TRACKER_STALL_EN
  task automatic test_stall();
    do_reset();
    window = 24'd1; rdy = 1'b1; enable = 1'b1;
    drive_cycles(4, 64'h0, 1'b0);
    n_vec++; if (stall_b !== 1'b0) begin n_bad++; $display("FAIL stall1 got %0b want 0", stall_b); end
    drive_cycles(3, 64'h0, 1'b0);
    n_vec++; if (stall_b !== 1'b1) begin n_bad++; $display("FAIL stall2 got %0b want 1", stall_b); end
    drive_cycles(3, 64'h1, 1'b0);
    n_vec++; if (ifb.snap_speed !== 16'sd1) begin n_bad++; $display("FAIL stall3_speed got %0d want 1", ifb.snap_speed); end
    n_vec++; if (stall_b !== 1'b0) begin n_bad++; $display("FAIL stall3 got %0b want 0", stall_b); end
    enable = 1'b0;
    tick(); tick();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    srst_n = 1'b0; enable = 1'b0; load = 1'b0; load_value = '0;
    direction = 1'b0; pulse = 1'b0; rdy = 1'b1; window = '0;
    tick();
    test_reset();
    test_count_up();
    test_count_down();
    test_wrap();
    test_saturation();
    test_back_to_back();
    test_load_and_midreset();
`ifdef QUAD_ENCODER_TRACKER_STALL_EN
    test_stall();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/quad_encoder_tracker.md
Name: quad_encoder_tracker

Overview:
Sequencer and accumulator downstream of the quadrature decoder. Consumes its per-step `direction`/`pulse` outputs and keeps a signed position count. Measures signed speed over a programmable window of clock cycles. Publishes one snapshot per window (position, speed, flags) through a valid/ready handshake to the motor-control loop or register bank.

Parameters:
POS_WIDTH, 32, width of signed position counter (wraps)
SPEED_WIDTH, 16, width of signed per-window speed count (saturates)
WINDOW_WIDTH, 24, width of window-length config
STALL_WINDOWS, 8, consecutive zero-speed windows that raise stall (optional feature only)

Ports:
clock  in  1  single clock domain
srst_n  in  1  synchronous reset, active-low
enable  in  1  1 = measure; 0 = return to IDLE
window  in  WINDOW_WIDTH  window length minus 1, in clocks (0 = 1-cycle window)
load  in  1  one-cycle strobe: position <= load_value
load_value  in  POS_WIDTH  preset position
direction  in  1  step direction from decoder: 0 = +1, 1 = -1
pulse  in  1  one-cycle step strobe from decoder
snap_valid  out  1  snapshot available
snap_ready  in  1  consumer accepts snapshot
snap_position  out  POS_WIDTH  position at window end
snap_speed  out  SPEED_WIDTH  signed step count over window
snap_sat  out  1  speed saturated during this window
snap_overrun  out  1  previous unread snapshot was overwritten
stall  out  1  optional feature; tied 0 when compiled out

Behaviour:
- Reset (srst_n=0 at posedge): all outputs 0, position 0, window counter 0, FSM IDLE. Reset mid-window discards the partial window and any pending snapshot.
- Position updates in every state, including IDLE: pulse=1 adds +1/-1 on the next edge and wraps two's complement (0x7FFFFFFF +1 -> 0x80000000).
- load=1 takes priority: position <= load_value; a pulse in the same cycle is dropped. load does not restart the window.
- FSM states:
  - IDLE: window counter and speed accumulator held at 0. enable=1 -> MEASURE.
  - MEASURE: counter increments each cycle. When counter == window, the cycle is the window end -> CAPTURE. enable=0 -> IDLE, with no snapshot for the partial window.
  - CAPTURE (1 cycle): snapshot registers load. Counter and accumulator restart at 0. Next state is MEASURE if enable=1, else IDLE.
- Speed accumulator: a pulse on the window-end cycle counts in the ending window.
  - Clamps to +2^(SPEED_WIDTH-1)-1 / -2^(SPEED_WIDTH-1) and sets the window's sat bit.
  - A pulse during CAPTURE counts in the new window; the accumulator starts at ±1.
- Snapshot position equals position after the window-end update, so a load on the window-end cycle is reflected.
- snap_valid rises the cycle after CAPTURE, with data stable. The transfer happens on the edge where snap_valid && snap_ready.
  - snap_valid drops next cycle unless a CAPTURE occurs on that same edge. If so, the new data is presented and snap_valid stays 1 with overrun=0.
- CAPTURE while snap_valid=1 and no handshake: data overwritten, snap_overrun=1 for the new snapshot.
- window changes take effect at the next window-end compare. Writing a window smaller than the current count runs the counter to wrap (2^WINDOW_WIDTH) before matching; firmware changes window only in IDLE.
- Latency: pulse -> reflected in snap_speed in the snapshot of the window containing it (2 cycles after window end).

Optional Feature:
QUAD_ENCODER_TRACKER_STALL_EN
- Defined: a counter of consecutive snapshots with snap_speed == 0 and enable=1. stall=1 once it reaches STALL_WINDOWS. Any nonzero-speed snapshot, enable=0, or reset clears both counter and stall. Counter saturates.
- Undefined: no counter logic; stall tied 0.

Decomposition:
- Package quad_encoder_pkg:
  - FSM state encoding (IDLE/MEASURE/CAPTURE)
  - SPEED_MAX/SPEED_MIN localparam functions of SPEED_WIDTH
- Sub-module quad_encoder_window_timer: window counter + window-end strobe. The tracker instantiates it, clearing it in IDLE and CAPTURE.

Test Plan:
- Reset, enable=1, window=9, 3 pulses dir=0 -> snapshot after cycle 10: speed=+3, position=3, sat=0, overrun=0.
- 5 pulses dir=1 from position 0 -> speed=-5, position=-5 (0xFFFFFFFB). Position 0x7FFFFFFF +1 -> 0x80000000.
- SPEED_WIDTH=4, 10 pulses dir=0 in one window -> speed=+7, sat=1. Next window, 1 pulse -> speed=+1, sat=0.
- snap_ready=0 across two windows -> second snapshot has overrun=1, first data lost. snap_ready=1 on the CAPTURE edge -> snap_valid stays 1, overrun=0.
- load=1 with load_value=1000 together with pulse on the window-end cycle -> snap_position=1000, and the pulse still counts in speed. srst_n=0 mid-window -> all outputs 0, no snapshot.
- STALL_EN, STALL_WINDOWS=2, no pulses -> stall=1 after 2nd snapshot. One pulse -> stall=0 at the next snapshot.
